// File: rtl/lockable_reg_bank.sv
// lockable_reg_bank: NUM_REGS configuration registers with per-register sticky
// lock bits plus a global lock-all. Writes to locked or out-of-range targets
// are dropped and flagged with wr_err; accepted writes pulse wr_ack.
// Optional build macro LOCKREG_VIOLATION_LOG_EN adds a rejected-write log
// (viol_count / viol_addr / viol_valid).

// One register plus its sticky lock bit. Write qualification is done by the
// bank so the cell stays a plain storage element.
module lockable_reg_cell #(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              lock_req,
   output logic [DATA_W-1:0] q,
   output logic              locked
);

   // data register and lock bit; the lock only ever sets until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= RESET_VAL;
         locked <= 1'b0;
      end else begin
         if (we) q <= wdata;
         locked <= locked | lock_req;
      end
   end

endmodule

module lockable_reg_bank #(
   parameter int                NUM_REGS  = 4,
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                clk,
   input  logic                rst_n,        // active-high synchronous reset
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                lock_set,
   input  logic [NUM_REGS-1:0] lock_mask,
   input  logic                lock_all,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic [NUM_REGS-1:0] lock_status,
   output logic                wr_err,
   output logic                wr_ack
`ifdef LOCKREG_VIOLATION_LOG_EN
   ,
   output logic [7:0]          viol_count,
   output logic [ADDR_W-1:0]   viol_addr,
   output logic                viol_valid
`endif
);

   logic [NUM_REGS-1:0]             wr_sel;
   logic [NUM_REGS-1:0]             rd_sel;
   logic [NUM_REGS-1:0][DATA_W-1:0] q;
   logic [DATA_W-1:0]               rd_next;
   logic                            addr_ok;
   logic                            tgt_locked;
   logic                            accept;
   logic                            reject;

   // one-hot address decode; an address past NUM_REGS decodes to all zeros,
   // which makes it both out of range for writes and zero for reads
   always_comb begin
      wr_sel = '0;
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_sel[i] = (wr_addr == ADDR_W'(i));
         rd_sel[i] = (rd_addr == ADDR_W'(i));
      end
   end

   // write qualification uses the lock bits held before this edge, so a lock
   // and a write to the same register in one cycle lets the write through
   assign addr_ok    = |wr_sel;
   assign tgt_locked = |(wr_sel & lock_status);
   assign accept     = wr_en & addr_ok & ~tgt_locked;
   assign reject     = wr_en & ~accept;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      lockable_reg_cell #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_cell (
         .clk      (clk),
         .rst      (rst_n),
         .we       (accept & wr_sel[g]),
         .wdata    (wr_data),
         .lock_req ((lock_set & lock_mask[g]) | lock_all),
         .q        (q[g]),
         .locked   (lock_status[g])
      );
   end

   // read mux from the pre-edge register values (read-during-write sees old data)
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rd_sel[i]) rd_next = q[i];
   end

   // registered read data and write response pulses
   always_ff @(posedge clk) begin
      if (rst_n) begin
         rd_data <= '0;
         wr_ack  <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         rd_data <= rd_next;
         wr_ack  <= accept;
         wr_err  <= reject;
      end
   end

`ifdef LOCKREG_VIOLATION_LOG_EN
   // rejected-write log: saturating count plus address of the first rejection
   always_ff @(posedge clk) begin
      if (rst_n) begin
         viol_count <= '0;
         viol_addr  <= '0;
         viol_valid <= 1'b0;
      end else if (reject) begin
         if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
         if (!viol_valid) begin
            viol_addr  <= wr_addr;
            viol_valid <= 1'b1;
         end
      end
   end
`endif

endmodule
